// File: rtl/posit_round_encode_8_es2.sv
// ---------------------------------------------------------------------------
// posit_round_encode_8_es2
//
// Rounds and packs the raw {sgn, scale, fraction, inf, zero} record from the
// posit adder into an 8-bit es=2 posit.
//
// The rounding is round-to-nearest-even on the posit bit string. Results
// saturate at maxpos (7'h7F) and minpos (7'h01). They never round to zero
// or to NaR.
//
// Pipeline ranks (one global advance enable, adv = ~out_valid | out_ready):
//   r0_  input capture of the raw record
//   r1_  decode: k = scale>>>2, e = scale[1:0], saturation flags
//   r2_  7-bit magnitude string with guard and sticky
//   r_out_ rounded, sign-applied posit (the output register)
// A sum accepted at edge N is presented with out_valid after edge N+3.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   in_valid     raw sum valid
//   in_ready     block can accept this cycle (combinational from adv)
//   in_sum       {sgn, scale[SCALE_W-1:0], fraction[FRAC_W-1:0], inf, zero}
//   in_trunc     adder truncated flag, folded into sticky
//   out_valid    out_posit / out_inexact valid
//   out_ready    downstream accepts
//   out_posit    packed posit8 es=2
//   out_inexact  guard|sticky was nonzero, or the scale saturated
// ---------------------------------------------------------------------------
module posit_round_encode_8_es2 #(
    parameter int SCALE_W = 8,
    parameter int FRAC_W  = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SCALE_W+FRAC_W+2:0]  in_sum,
    input  logic                       in_trunc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_posit,
    output logic                       out_inexact
);

    // Layout of the regime/exp/fraction string before it is cut into
    // mag | guard | sticky. It has 8 regime slots, 1 terminator, 2 exponent
    // bits, the fraction, and 7 pad bits that absorb the regime shift.
    localparam int STR_W = FRAC_W + 18;

    localparam logic signed [SCALE_W-1:0] SCALE_MAX = SCALE_W'(24);
    localparam logic signed [SCALE_W-1:0] SCALE_MIN = -SCALE_W'(24);

    logic w_adv;

    // rank 0: captured record
    logic                      r0_valid;
    logic                      r0_sgn;
    logic signed [SCALE_W-1:0] r0_scale;
    logic [FRAC_W-1:0]         r0_frac;
    logic                      r0_inf;
    logic                      r0_zero;
    logic                      r0_trunc;

    // rank 1: decoded scale
    logic                      r1_valid;
    logic                      r1_sgn;
    logic signed [3:0]         r1_k;
    logic [1:0]                r1_e;
    logic [FRAC_W-1:0]         r1_frac;
    logic                      r1_clamp_hi;
    logic                      r1_clamp_lo;
    logic                      r1_inf;
    logic                      r1_zero;
    logic                      r1_trunc;

    // rank 2: truncated magnitude
    logic                      r2_valid;
    logic                      r2_sgn;
    logic [6:0]                r2_mag;
    logic                      r2_guard;
    logic                      r2_sticky;
    logic                      r2_clamped;
    logic                      r2_inf;
    logic                      r2_zero;

    // output rank
    logic                      r_out_valid;
    logic [7:0]                r_out_posit;
    logic                      r_out_inexact;

    assign w_adv       = ~r_out_valid | out_ready;
    assign in_ready    = w_adv;
    assign out_valid   = r_out_valid;
    assign out_posit   = r_out_posit;
    assign out_inexact = r_out_inexact;

    // -----------------------------------------------------------------------
    // Rank 0: capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_valid <= 1'b0;
        end else if (w_adv) begin
            r0_valid <= in_valid;
            if (in_valid) begin
                r0_sgn   <= in_sum[SCALE_W+FRAC_W+2];
                r0_scale <= in_sum[SCALE_W+FRAC_W+1 -: SCALE_W];
                r0_frac  <= in_sum[FRAC_W+1 -: FRAC_W];
                r0_inf   <= in_sum[1];
                r0_zero  <= in_sum[0];
                r0_trunc <= in_trunc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Rank 1: decode. Only scales inside [-24, 24] use k, so k always lies in
    // [-6, 6]. The 4-bit slice scale[5:2] equals scale>>>2 over that range.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
        end else if (w_adv) begin
            r1_valid    <= r0_valid;
            r1_sgn      <= r0_sgn;
            r1_k        <= r0_scale[5:2];
            r1_e        <= r0_scale[1:0];
            r1_frac     <= r0_frac;
            r1_clamp_hi <= (r0_scale > SCALE_MAX);
            r1_clamp_lo <= (r0_scale < SCALE_MIN);
            r1_inf      <= r0_inf;
            r1_zero     <= r0_zero;
            r1_trunc    <= r0_trunc;
        end
    end

    // -----------------------------------------------------------------------
    // Rank 2: build the magnitude string.
    // When k >= 0, the string starts from eight ones. A left shift of 7-k
    // leaves k+1 ones, then the terminator zero.
    // When k < 0, the string starts with the terminator one. A right shift
    // of -k puts -k zeros ahead of it.
    // -----------------------------------------------------------------------
    logic [2:0]       w_sh;
    logic [STR_W-1:0] w_str;
    logic [6:0]       w_mag;
    logic             w_guard;
    logic             w_sticky;

    always_comb begin
        w_sh  = '0;
        w_str = '0;
        if (!r1_k[3]) begin
            w_sh  = 3'd7 - r1_k[2:0];
            w_str = {8'hFF, 1'b0, r1_e, r1_frac, 7'b0} << w_sh;
        end else begin
            w_sh  = (~r1_k[2:0]) + 3'd1;
            w_str = {1'b1, r1_e, r1_frac, 15'b0} >> w_sh;
        end
    end

    assign w_mag    = w_str[STR_W-1 -: 7];
    assign w_guard  = w_str[STR_W-8];
    assign w_sticky = (|w_str[STR_W-9:0]) | r1_trunc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r2_valid <= 1'b0;
        end else if (w_adv) begin
            r2_valid   <= r1_valid;
            r2_sgn     <= r1_sgn;
            r2_inf     <= r1_inf;
            r2_zero    <= r1_zero;
            r2_clamped <= r1_clamp_hi | r1_clamp_lo;
            if (r1_clamp_hi) begin
                r2_mag    <= 7'h7F;
                r2_guard  <= 1'b0;
                r2_sticky <= 1'b0;
            end else if (r1_clamp_lo) begin
                r2_mag    <= 7'h01;
                r2_guard  <= 1'b0;
                r2_sticky <= 1'b0;
            end else begin
                r2_mag    <= w_mag;
                r2_guard  <= w_guard;
                r2_sticky <= w_sticky;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output rank: round to nearest even, saturate, apply sign, handle
    // specials.
    // -----------------------------------------------------------------------
    logic       w_round_up;
    logic [6:0] w_mag_rnd;
    logic [6:0] w_mag_fin;
    logic [7:0] w_posit;
    logic       w_inexact;

    always_comb begin
        w_round_up = r2_guard & (r2_mag[0] | r2_sticky) & (r2_mag != 7'h7F);
        w_mag_rnd  = r2_mag + {6'b0, w_round_up};
        // minpos is the floor. A posit never rounds to zero.
        w_mag_fin  = (w_mag_rnd == 7'h00) ? 7'h01 : w_mag_rnd;
        w_posit    = r2_sgn ? (8'h00 - {1'b0, w_mag_fin}) : {1'b0, w_mag_fin};
        w_inexact  = r2_guard | r2_sticky | r2_clamped;
        if (r2_inf) begin
            w_posit   = 8'h80;
            w_inexact = 1'b0;
        end else if (r2_zero) begin
            w_posit   = 8'h00;
            w_inexact = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_posit   <= 8'h00;
            r_out_inexact <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_out_posit   <= w_posit;
                r_out_inexact <= w_inexact;
            end
        end
    end

endmodule

// File: tb/tb_posit_round_encode_8_es2.sv
module tb_posit_round_encode_8_es2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [40:0] in_sum;
    logic        in_trunc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_posit;
    logic        out_inexact;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit        sgn;
        int        scale;
        bit [29:0] frac;
        bit        inf;
        bit        zero;
        bit        trunc;
    } item_t;

    typedef struct {
        bit [7:0] p;
        bit       x;
    } exp_t;

    posit_round_encode_8_es2 dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_trunc    (in_trunc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_posit   (out_posit),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: write the posit bit string out one bit at a time, then round
    // on the string as an integer.
    function automatic exp_t model(input item_t it);
        exp_t r;
        int   mag;
        int   e;
        int   k;
        bit   bits[$];
        bit   guard;
        bit   sticky;
        r.p = 8'h00;
        r.x = 1'b0;
        if (it.inf)  begin r.p = 8'h80; return r; end
        if (it.zero) begin r.p = 8'h00; return r; end
        if (it.scale > 24) begin
            mag = 127; r.x = 1'b1;
        end else if (it.scale < -24) begin
            mag = 1; r.x = 1'b1;
        end else begin
            e = ((it.scale % 4) + 4) % 4;
            k = (it.scale - e) / 4;
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[1]);
            bits.push_back(e[0]);
            for (int i = 29; i >= 0; i--) bits.push_back(it.frac[i]);
            mag = 0;
            for (int i = 0; i < 7; i++) mag = mag * 2 + int'(bits[i]);
            guard  = bits[7];
            sticky = it.trunc;
            for (int i = 8; i < bits.size(); i++) sticky |= bits[i];
            r.x = guard | sticky;
            if (guard && (sticky || (mag % 2 == 1)) && mag < 127) mag++;
            if (mag == 0) mag = 1;
        end
        r.p = it.sgn ? 8'((256 - mag) % 256) : 8'(mag);
        return r;
    endfunction

    function automatic item_t mk(bit sgn, int scale, bit [29:0] frac,
                                 bit inf, bit zero, bit trunc);
        item_t it;
        it.sgn = sgn; it.scale = scale; it.frac = frac;
        it.inf = inf; it.zero = zero; it.trunc = trunc;
        return it;
    endfunction

    function automatic item_t rand_item();
        item_t it;
        it.sgn   = 1'($urandom_range(0, 1));
        it.scale = int'($urandom_range(0, 64)) - 32;
        it.frac  = 30'($urandom);
        if ($urandom_range(0, 3) == 0) it.frac = it.frac & 30'h3FF0_0000;
        it.inf   = ($urandom_range(0, 15) == 0);
        it.zero  = ($urandom_range(0, 15) == 0);
        it.trunc = ($urandom_range(0, 3) == 0);
        return it;
    endfunction

    task automatic drive(input item_t it);
        in_sum   = {it.sgn, 8'(it.scale), it.frac, it.inf, it.zero};
        in_trunc = it.trunc;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Sends one item into an idle pipe and waits for its result. Returns the
    // number of edges between acceptance and out_valid (10 means timeout).
    task automatic single(input item_t it, output logic [7:0] p,
                          output logic x, output int lat);
        out_ready = 1'b1;
        drive(it);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        p = out_posit;
        x = out_inexact;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_posit !== 8'h00) begin n_err++; $display("FAIL reset_out_posit got %h want 00", out_posit); end
        n_cmp++; if (out_inexact !== 1'b0) begin n_err++; $display("FAIL reset_out_inexact got %b want 0", out_inexact); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        item_t      its[14];
        bit [7:0]   wp[14];
        bit         wx[14];
        logic [7:0] p;
        logic       x;
        int         lat;
        its[0]  = mk(0,   0, 30'h0,         0, 0, 0); wp[0]  = 8'h40; wx[0]  = 0;
        its[1]  = mk(1,   0, 30'h0,         0, 0, 0); wp[1]  = 8'hC0; wx[1]  = 0;
        its[2]  = mk(0,   1, 30'h0,         0, 0, 0); wp[2]  = 8'h48; wx[2]  = 0;
        its[3]  = mk(0,  -1, 30'h0,         0, 0, 0); wp[3]  = 8'h38; wx[3]  = 0;
        its[4]  = mk(0,   0, 30'h0400_0000, 0, 0, 0); wp[4]  = 8'h40; wx[4]  = 1;
        its[5]  = mk(0,   0, 30'h0C00_0000, 0, 0, 0); wp[5]  = 8'h42; wx[5]  = 1;
        its[6]  = mk(0,   0, 30'h0400_0000, 0, 0, 1); wp[6]  = 8'h41; wx[6]  = 1;
        its[7]  = mk(0,  24, 30'h0,         0, 0, 0); wp[7]  = 8'h7F; wx[7]  = 0;
        its[8]  = mk(0,  30, 30'h0,         0, 0, 0); wp[8]  = 8'h7F; wx[8]  = 1;
        its[9]  = mk(0, -24, 30'h0,         0, 0, 0); wp[9]  = 8'h01; wx[9]  = 0;
        its[10] = mk(1, -30, 30'h0,         0, 0, 0); wp[10] = 8'hFF; wx[10] = 1;
        its[11] = mk(0,   5, 30'h2AAA_AAAA, 1, 1, 1); wp[11] = 8'h80; wx[11] = 0;
        its[12] = mk(1,  -7, 30'h1555_5555, 0, 1, 1); wp[12] = 8'h00; wx[12] = 0;
        its[13] = mk(1,  24, 30'h3FFF_FFFF, 0, 0, 0); wp[13] = 8'h81; wx[13] = 1;
        for (int i = 0; i < 14; i++) begin
            single(its[i], p, x, lat);
            n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL directed_%0d_latency got %0d want 3", i, lat); end
            n_cmp++; if (p !== wp[i]) begin n_err++; $display("FAIL directed_%0d_posit got %h want %h", i, p, wp[i]); end
            n_cmp++; if (x !== wx[i]) begin n_err++; $display("FAIL directed_%0d_inexact got %b want %b", i, x, wx[i]); end
        end
    endtask

    // Streaming run against the model. When toggle is set, inputs are offered
    // every cycle and out_ready toggles 1,0,1,0... Otherwise both are random.
    task automatic test_stream(input int n, input bit toggle, input string tag);
        item_t      items[$];
        exp_t       expq[$];
        exp_t       e;
        int         sent;
        int         recv;
        int         cyc;
        bit         stalled;
        logic [7:0] held_p;
        logic       held_x;
        for (int i = 0; i < n; i++) items.push_back(rand_item());
        sent = 0; recv = 0; cyc = 0; stalled = 0;
        held_p = '0; held_x = '0;
        while (recv < n && cyc < 2000) begin
            if (sent < n && (toggle || $urandom_range(0, 3) != 0)) begin
                drive(items[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n_cmp++; if (in_ready !== (!out_valid || out_ready)) begin n_err++; $display("FAIL %s_in_ready cyc %0d got %b want %b", tag, cyc, in_ready, !out_valid || out_ready); end
            if (stalled) begin
                n_cmp++; if (out_valid !== 1'b1 || out_posit !== held_p || out_inexact !== held_x) begin n_err++; $display("FAIL %s_hold cyc %0d got %b/%h/%b want 1/%h/%b", tag, cyc, out_valid, out_posit, out_inexact, held_p, held_x); end
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL %s_extra_output cyc %0d got %h want none", tag, cyc, out_posit);
                end else begin
                    e = expq.pop_front();
                    n_cmp++; if (out_posit !== e.p || out_inexact !== e.x) begin n_err++; $display("FAIL %s_data #%0d got %h/%b want %h/%b", tag, recv, out_posit, out_inexact, e.p, e.x); end
                end
                recv++;
            end
            stalled = out_valid && !out_ready;
            held_p  = out_posit;
            held_x  = out_inexact;
            if (in_valid && in_ready) begin
                expq.push_back(model(items[sent]));
                sent++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (recv < n) begin n_err++; $display("FAIL %s_timeout got %0d results want %0d", tag, recv, n); end
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_duplicate got out_valid %b want 0", tag, out_valid); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        item_t      it;
        exp_t       e;
        logic [7:0] p;
        logic       x;
        int         lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, i, 30'h0, 0, 0, 0));
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_first_cycle got out_valid %b want 0", out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_ghost cyc %0d got out_valid %b want 0", i, out_valid); end
        end
        it = mk(1, 3, 30'h1234_5678, 0, 0, 0);
        e  = model(it);
        single(it, p, x, lat);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL midreset_latency got %0d want 3", lat); end
        n_cmp++; if (p !== e.p || x !== e.x) begin n_err++; $display("FAIL midreset_data got %h/%b want %h/%b", p, x, e.p, e.x); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_trunc  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_stream(8, 1'b1, "back_to_back");
        test_stream(300, 1'b0, "random");
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
